dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Round-robin arbiter that shares the single-port data memory between two requesters: requester 0 (pipeline MEM stage) and requester 1 (DMA/array loader). It grants one owner at a time, forwards that owner's address, write data and write enable to the memory, and returns registered read data. Locked bursts of up to `MAX_BURST` beats are supported. It sits between the datapath/loader and the data memory.

## Interface
- `AW`, 32, address width (byte address, forwarded unmodified)
- `DW`, 32, data width
- `MAX_BURST`, 8, max beats per tenure while locked (≥1)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req0`/`req1`  in  1  access request, held until the beat is taken
- `lock0`/`lock1`  in  1  keep ownership after the current beat (burst)
- `we0`/`we1`  in  1  1 = write, 0 = read
- `addr0`/`addr1`  in  AW  byte address
- `wdata0`/`wdata1`  in  DW  write data
- `gnt0`/`gnt1`  out  1  registered ownership flag
- `rvalid0`/`rvalid1`  out  1  read data valid, one cycle after a read beat
- `rdata0`/`rdata1`  out  DW  registered read data
- `mem_addr`  out  AW  to memory address
- `mem_wdata`  out  DW  to memory write data
- `mem_we`  out  1  to memory write enable
- `mem_rdata`  in  DW  combinational memory read data
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, OWN0, OWN1. `gntX` = (state == OWNX), registered.
- `last` register holds the most recently granted requester; reset value 1, so requester 0 wins the first contention.
- IDLE: neither request → stay. One request → OWN of that one. Both → OWN of the requester ≠ `last`.
- Beat: the cycle where `gntX & reqX`. Muxes drive `mem_addr=addrX`, `mem_wdata=wdataX`, `mem_we=weX`. The write commits at that clock edge.
- Outside a beat: `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- Read beat: `mem_rdata` is captured into `rdataX`, and `rvalidX` pulses the next cycle. `rdataX` holds its value until the next read for X. A write beat never raises `rvalid`.
- `beat_cnt` counts beats in the current tenure and clears on every ownership change.
- Release occurs at the end of the cycle in which any of these holds:
  - a beat with `lockX=0`;
  - a beat with `beat_cnt==MAX_BURST-1`, forced even if locked;
  - owned with `reqX=0`, no beat.
- Release arbitration:
  - Other requester requesting → OWN other.
  - Else same requester still requesting → OWN same, with `beat_cnt` cleared.
  - Else → IDLE.
- `last` updates on every new grant.
- No alignment check: the full address is passed; the memory word-indexes it.

## Timing
- Reset values:
  - state IDLE, `last=1`, `beat_cnt=0`;
  - `gnt0/1=0`, `rvalid0/1=0`, `rdata0/1=0`, `busy=0`;
  - `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- Latency from IDLE: `req` sampled at edge N → `gnt` high in cycle N+1 → beat in N+1 → `rvalid`/`rdata` in N+2.
- Back-to-back beats: one beat per cycle while locked. Ownership handoff has no bubble: release at beat M → new owner's `gnt` in M+1.
- Requesters may change `addr`/`we`/`wdata` only after a beat. A non-owner's request is held without loss.
- Simultaneous `req` rise from IDLE: the one ≠ `last` wins. The loser is granted immediately after the winner releases.
- Reset asserted mid-burst: asynchronously forces IDLE. `mem_we` drops immediately and no further writes occur. Pending `rvalid` is cleared.
- `MAX_BURST=1`: every beat releases; with both requesting, grants strictly alternate.

## Test plan
- Reset, then `req0` read at `addr0=0x8` with memory word 2 = `0xDEADBEEF` → `gnt0` cycle 1, `mem_we=0`, `rvalid0=1`, `rdata0=0xDEADBEEF` cycle 2; `busy` back to 0 after release.
- `req1` write `addr1=0x10`, `wdata1=0x12345678`, then `req1` read `0x10` → memory word 4 written; read returns `0x12345678`; `rvalid1` never pulses for the write.
- `req0` and `req1` rise same cycle after reset, neither locked, both held for 6 beats → grants alternate 0,1,0,1,… starting with 0, with no idle cycle between grants.
- `req0` with `lock0=1` held for 12 beats while `req1` is pending → exactly 8 consecutive OWN0 beats, then OWN1 for 1 beat, then OWN0 resumes.
- Owner 1 drops `req1` while granted → no beat, `mem_we=0`, release next cycle to IDLE (or to 0 if `req0` is high).
- `rst` pulled low mid-way through a locked write burst from requester 0 → `mem_we`, `gnt0`, `rvalid0` go to 0 immediately; after release, the first grant goes to requester 0 per `last=1`.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester/memory-side signal bundle for the two-port data memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          lock0, lock1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the MEM stage
// (requester 0) and the DMA loader (requester 1), with locked bursts of up to MAX_BURST beats.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int             CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic beat0, beat1;
    logic own_req, own_lock, other_req, release_own;

    // A beat needs both ownership (registered) and a live request from the owner.
    assign beat0 = (state_q == OWN0) && bus.req0;
    assign beat1 = (state_q == OWN1) && bus.req1;

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (beat0) begin
            bus.mem_we    = bus.we0;
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
        end else if (beat1) begin
            bus.mem_we    = bus.we1;
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        own_req     = 1'b0;
        own_lock    = 1'b0;
        other_req   = 1'b0;
        case (state_q)
            OWN0: begin
                own_req   = bus.req0;
                own_lock  = bus.lock0;
                other_req = bus.req1;
            end
            OWN1: begin
                own_req   = bus.req1;
                own_lock  = bus.lock1;
                other_req = bus.req0;
            end
            default: ;
        endcase
        // Owner gives up after an unlocked beat, the last allowed burst beat, or an idle cycle.
        release_own = !own_req || !own_lock || (cnt_q == CNT_LAST);

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (bus.req0 && (!bus.req1 || last_q)) begin
                state_d = OWN0;
                last_d  = 1'b0;
            end else if (bus.req1) begin
                state_d = OWN1;
                last_d  = 1'b1;
            end
        end else if (release_own) begin
            cnt_d = '0;
            if (other_req) begin
                state_d = (state_q == OWN0) ? OWN1 : OWN0;
                last_d  = (state_q == OWN0);
            end else if (!own_req) begin
                state_d = IDLE;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= beat0 && !bus.we0;
            rvalid1_q <= beat1 && !bus.we1;
            if (beat0 && !bus.we0) rdata0_q <= bus.mem_rdata;
            if (beat1 && !bus.we1) rdata1_q <= bus.mem_rdata;
        end
    end

    assign bus.gnt0    = (state_q == OWN0);
    assign bus.gnt1    = (state_q == OWN1);
    assign bus.busy    = (state_q != IDLE);
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized phase, with read data
// predicted from a word-level memory model and checked by an independent monitor.
module tb_dmem_arbiter;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 8;
    localparam int BOUND     = MAX_BURST + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 2) ? 32'hDEADBEEF : (32'hC0DE_0000 | DW'(i));
    endfunction

    // Word-indexed memory behind the arbiter; combinational read, write at the edge.
    logic [DW-1:0] mem [0:63];
    logic          preload = 1'b0;
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    int            beat_own[$];
    int            beat_cyc[$];
    logic [DW-1:0] ref_mem [0:63];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input int r, input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (r == 0) begin
            bus.req0 = req; bus.we0 = we; bus.lock0 = lock; bus.addr0 = addr; bus.wdata0 = wd;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.lock1 = lock; bus.addr1 = addr; bus.wdata1 = wd;
        end
    endtask

    task automatic drop(input int r);
        drive(r, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Issue one beat and hold it until granted; the expected read result is queued for the monitor.
    task automatic do_beat(input int r, input logic we, input logic lock, input int word,
                           input logic [DW-1:0] wd, output int waited);
        logic g;
        exp_t e;
        g = 1'b0;
        drive(r, 1'b1, we, lock, AW'(word * 4), wd);
        waited = 0;
        forever begin
            @(negedge clk);
            g = (r == 0) ? bus.gnt0 : bus.gnt1;
            if (g) break;
            waited++;
            if (waited > 100) begin
                chk("beat_timeout", g, 1);
                break;
            end
        end
        if (g) begin
            chk("beat_addr", bus.mem_addr, AW'(word * 4));
            chk("beat_we", bus.mem_we, we);
            if (we) begin
                chk("beat_wdata", bus.mem_wdata, wd);
                ref_mem[word] = wd;
            end else begin
                e.data = ref_mem[word];
                e.due  = cyc + 1;
                if (r == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end
            $display("beat r=%0d we=%0d lock=%0d word=%0d data=0x%08h cyc=%0d",
                     r, we, lock, word, we ? wd : ref_mem[word], cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        drop(0);
        drop(1);
        repeat (2) @(negedge clk);
        chk("reset_flags", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, bus.mem_we}, 0);
        chk("reset_rdata", bus.rdata0 | bus.rdata1, 0);
        chk("reset_mem_bus", bus.mem_addr | bus.mem_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        beat_own.delete();
        beat_cyc.delete();
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Monitor: read-data scoreboard, idle-bus rule, single owner, beat trace, bounded waiting.
    initial begin
        int   w0, w1;
        exp_t e;
        w0 = 0;
        w1 = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                w0 = 0;
                w1 = 0;
            end else begin
                if (bus.rvalid0) begin
                    if (exp_q0.size() == 0) chk("rvalid0_unexpected", bus.rvalid0, 0);
                    else begin
                        e = exp_q0.pop_front();
                        chk("rdata0", bus.rdata0, e.data);
                        chk("rvalid0_cycle", cyc, e.due);
                    end
                end
                if (bus.rvalid1) begin
                    if (exp_q1.size() == 0) chk("rvalid1_unexpected", bus.rvalid1, 0);
                    else begin
                        e = exp_q1.pop_front();
                        chk("rdata1", bus.rdata1, e.data);
                        chk("rvalid1_cycle", cyc, e.due);
                    end
                end
                chk("single_owner", bus.gnt0 & bus.gnt1, 0);
                if (!(bus.gnt0 && bus.req0) && !(bus.gnt1 && bus.req1)) begin
                    chk("idle_mem_we", bus.mem_we, 0);
                    chk("idle_mem_bus", bus.mem_addr | bus.mem_wdata, 0);
                end
                if (bus.gnt0 && bus.req0) begin
                    beat_own.push_back(0);
                    beat_cyc.push_back(cyc);
                    chk("wait0_bound", w0 <= BOUND, 1);
                    w0 = 0;
                end else if (bus.req0) w0++;
                else w0 = 0;
                if (bus.gnt1 && bus.req1) begin
                    beat_own.push_back(1);
                    beat_cyc.push_back(cyc);
                    chk("wait1_bound", w1 <= BOUND, 1);
                    w1 = 0;
                end else if (bus.req1) w1++;
                else w1 = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        drop(0);
        drop(1);
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;

        // Single read from IDLE: grant the cycle after the request, data the cycle after the beat.
        reset_dut();
        do_beat(0, 1'b0, 1'b0, 2, '0, n);
        chk("t1_gnt_latency", n, 1);
        drop(0);
        repeat (2) @(negedge clk);
        chk("t1_busy_released", bus.busy, 0);

        // Write then read back through requester 1.
        do_beat(1, 1'b1, 1'b0, 4, 32'h12345678, n);
        do_beat(1, 1'b0, 1'b0, 4, '0, n);
        drop(1);
        @(negedge clk);
        chk("t2_mem_word4", mem[4], 32'h12345678);

        // Simultaneous unlocked requests: strict alternation starting with 0, no gaps.
        reset_dut();
        fork
            begin
                int m;
                for (int k = 0; k < 6; k++) do_beat(0, 1'b1, 1'b0, 8 + k, $urandom, m);
                drop(0);
            end
            begin
                int m;
                for (int k = 0; k < 6; k++) do_beat(1, 1'b1, 1'b0, 40 + k, $urandom, m);
                drop(1);
            end
        join
        chk("t3_beat_count", beat_own.size(), 12);
        for (int k = 0; k < 12 && k < beat_own.size(); k++) begin
            chk("t3_owner", beat_own[k], k % 2);
            chk("t3_no_bubble", beat_cyc[k] - beat_cyc[0], k);
        end

        // Locked burst capped at MAX_BURST beats while requester 1 waits.
        reset_dut();
        fork
            begin
                int m;
                for (int k = 0; k < 12; k++) do_beat(0, 1'b1, 1'b1, 16 + (k % 8), $urandom, m);
                drop(0);
            end
            begin
                int m;
                do_beat(1, 1'b0, 1'b0, 33, '0, m);
                drop(1);
            end
        join
        chk("t4_beat_count", beat_own.size(), 13);
        for (int k = 0; k < 13 && k < beat_own.size(); k++) begin
            chk("t4_owner", beat_own[k], (k == MAX_BURST) ? 1 : 0);
            chk("t4_no_bubble", beat_cyc[k] - beat_cyc[0], k);
        end

        // Owner 1 withdraws its request while granted: no beat, immediate handoff to 0.
        reset_dut();
        drive(1, 1'b1, 1'b0, 1'b0, AW'(36 * 4), '0);
        @(posedge clk);
        #1;
        drop(1);
        do_beat(0, 1'b0, 1'b0, 20, '0, n);
        chk("t5_handoff", n, 1);
        drop(0);
        repeat (2) @(negedge clk);
        chk("t5_idle", bus.busy, 0);

        // Reset in the middle of a locked write burst.
        reset_dut();
        do_beat(0, 1'b1, 1'b1, 24, $urandom, n);
        do_beat(0, 1'b1, 1'b1, 25, $urandom, n);
        do_beat(0, 1'b0, 1'b1, 24, '0, n);
        drive(0, 1'b1, 1'b1, 1'b1, AW'(26 * 4), 32'hBAD0BAD0);
        @(negedge clk);
        chk("t6_we_before_rst", bus.mem_we, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_we_async", bus.mem_we, 0);
        chk("t6_gnt0_async", bus.gnt0, 0);
        chk("t6_rvalid0_async", bus.rvalid0, 0);
        chk("t6_busy_async", bus.busy, 0);
        reset_dut();
        fork
            begin
                int m;
                do_beat(0, 1'b0, 1'b0, 27, '0, m);
                drop(0);
            end
            begin
                int m;
                do_beat(1, 1'b0, 1'b0, 37, '0, m);
                drop(1);
            end
        join
        chk("t6_first_owner", (beat_own.size() > 0) ? beat_own[0] : -1, 0);

        // Randomized traffic in disjoint regions with random locks and idle gaps.
        reset_dut();
        fork
            begin
                int m;
                for (int k = 0; k < 80; k++) begin
                    do_beat(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                            48 + int'($urandom_range(0, 7)), $urandom, m);
                    if ($urandom_range(0, 3) == 0) begin
                        drop(0);
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                drop(0);
            end
            begin
                int m;
                for (int k = 0; k < 80; k++) begin
                    do_beat(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                            56 + int'($urandom_range(0, 7)), $urandom, m);
                    if ($urandom_range(0, 3) == 0) begin
                        drop(1);
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                drop(1);
            end
        join

        repeat (4) @(negedge clk);
        chk("exp_q0_drained", exp_q0.size(), 0);
        chk("exp_q1_drained", exp_q1.size(), 0);
        for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
